// File: rtl/kernel_sched_pkg.sv
// Shared types for the kernel scheduler: state encoding and default index width.
package kernel_sched_pkg;

    localparam int CH_W_DEFAULT = 9;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_PRIME = 3'd2,
        S_CONV  = 3'd3,
        S_WAIT  = 3'd4,
        S_NEXT  = 3'd5,
        S_FIN   = 3'd6
    } state_e;

endpackage

// File: rtl/kernel_sched_wdog.sv
// Watchdog for the scheduler's open-ended waits; counts while run_i is high and
// restarts on every state entry. Only instantiated when KSCHED_WDOG_EN is defined.
module kernel_sched_wdog #(
    parameter int LIMIT = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    input  logic restart_i,
    output logic expire_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Expiry is flagged in the cycle whose closing edge would be the LIMIT-th one.
    assign expire_o = run_i && (cnt_q == CW'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i || !run_i) begin
            cnt_d = '0;
        end else if (!expire_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/kernel_sched.sv
// Kernel scheduler: sequences kernel load, BRAM read prime and conv passes over
// input/output channels of one layer. Optional watchdog under KSCHED_WDOG_EN.
module kernel_sched
    import kernel_sched_pkg::*;
#(
    parameter int CH_W        = CH_W_DEFAULT,
    parameter int WDOG_CYCLES = 65535
) (
    input  logic            clk,
    input  logic            Reset,
    input  logic            start,
    input  logic            abort,
    input  logic [CH_W-1:0] CHANNEL_SIZE,
    input  logic [CH_W-1:0] OUT_CHANNEL_SIZE,
    input  logic            last_loading_1ker,
    input  logic            last_channel,
    input  logic            conv_done,
    output logic            load_BRAM_dina,
    output logic            update_BRAM_doutb,
    output logic            conv_start,
    output logic            acc_clear,
    output logic            och_done,
    output logic [CH_W-1:0] in_ch_idx,
    output logic [CH_W-1:0] out_ch_idx,
    output logic            busy,
    output logic            done,
    output logic            err
);

    if (WDOG_CYCLES < 2) begin : g_bad_wdog
        $error("WDOG_CYCLES must be at least 2");
    end

    state_e          state_q, state_d;
    logic [CH_W-1:0] ch_size_q, ch_size_d, och_size_q, och_size_d;
    logic [CH_W-1:0] in_idx_q, in_idx_d, out_idx_q, out_idx_d;
    logic            err_q, err_d;
    logic            load_q, load_d, upd_q, upd_d, cstart_q, cstart_d;
    logic            aclr_q, aclr_d, ochd_q, ochd_d, done_q, done_d;
    logic            in_last, out_last, wdog_expire;

    assign in_last  = (in_idx_q == ch_size_q - CH_W'(1));
    assign out_last = (out_idx_q == och_size_q - CH_W'(1));

`ifdef KSCHED_WDOG_EN
    kernel_sched_wdog #(.LIMIT(WDOG_CYCLES)) u_wdog (
        .clk       (clk),
        .rst_n     (Reset),
        .run_i     ((state_q == S_LOAD) || (state_q == S_WAIT)),
        .restart_i (state_d != state_q),
        .expire_o  (wdog_expire)
    );
`else
    assign wdog_expire = 1'b0;
`endif

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        ch_size_d  = ch_size_q;
        och_size_d = och_size_q;
        in_idx_d   = in_idx_q;
        out_idx_d  = out_idx_q;
        err_d      = err_q;
        // Strobes are registered from the current state, so they trail it by one cycle.
        load_d     = (state_q == S_LOAD);
        upd_d      = (state_q == S_PRIME);
        cstart_d   = (state_q == S_CONV);
        aclr_d     = (state_q == S_CONV) && (in_idx_q == '0);
        ochd_d     = (state_q == S_NEXT) && in_last;
        done_d     = (state_q == S_FIN);

        if (abort || wdog_expire) begin
            state_d   = S_IDLE;
            in_idx_d  = '0;
            out_idx_d = '0;
            load_d    = 1'b0;
            upd_d     = 1'b0;
            cstart_d  = 1'b0;
            aclr_d    = 1'b0;
            ochd_d    = 1'b0;
            done_d    = 1'b0;
            if (!abort) err_d = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: if (start) begin
                    ch_size_d  = CHANNEL_SIZE;
                    och_size_d = OUT_CHANNEL_SIZE;
                    in_idx_d   = '0;
                    out_idx_d  = '0;
                    if (CHANNEL_SIZE == '0 || OUT_CHANNEL_SIZE == '0) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_LOAD;
                    end
                end
                S_LOAD:  if (last_loading_1ker) state_d = S_PRIME;
                S_PRIME: state_d = S_CONV;
                S_CONV:  state_d = S_WAIT;
                S_WAIT:  if (conv_done) state_d = S_NEXT;
                S_NEXT: begin
                    if (last_channel != in_last) err_d = 1'b1;
                    if (!in_last) begin
                        in_idx_d = in_idx_q + CH_W'(1);
                        state_d  = S_PRIME;
                    end else begin
                        in_idx_d = '0;
                        if (out_last) begin
                            state_d = S_FIN;
                        end else begin
                            out_idx_d = out_idx_q + CH_W'(1);
                            state_d   = S_LOAD;
                        end
                    end
                end
                S_FIN: begin
                    in_idx_d  = '0;
                    out_idx_d = '0;
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            ch_size_q  <= '0;
            och_size_q <= '0;
            in_idx_q   <= '0;
            out_idx_q  <= '0;
            err_q      <= 1'b0;
            load_q     <= 1'b0;
            upd_q      <= 1'b0;
            cstart_q   <= 1'b0;
            aclr_q     <= 1'b0;
            ochd_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_size_q  <= ch_size_d;
            och_size_q <= och_size_d;
            in_idx_q   <= in_idx_d;
            out_idx_q  <= out_idx_d;
            err_q      <= err_d;
            load_q     <= load_d;
            upd_q      <= upd_d;
            cstart_q   <= cstart_d;
            aclr_q     <= aclr_d;
            ochd_q     <= ochd_d;
            done_q     <= done_d;
        end
    end

    assign load_BRAM_dina    = load_q;
    assign update_BRAM_doutb = upd_q;
    assign conv_start        = cstart_q;
    assign acc_clear         = aclr_q;
    assign och_done          = ochd_q;
    assign done              = done_q;
    assign err               = err_q;
    assign in_ch_idx         = in_idx_q;
    assign out_ch_idx        = out_idx_q;
    assign busy              = (state_q != S_IDLE);

endmodule

// File: tb/tb_kernel_sched.sv
// Directed bench for kernel_sched: nominal layer, latency, zero size, abort,
// last_channel fault, reset mid-LOAD, and watchdog expiry when KSCHED_WDOG_EN is set.
module tb_kernel_sched;

    localparam int CH_W = 9;

    logic            clk = 1'b0;
    logic            Reset = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [CH_W-1:0] CHANNEL_SIZE = '0;
    logic [CH_W-1:0] OUT_CHANNEL_SIZE = '0;
    logic            last_loading_1ker = 1'b0;
    logic            last_channel = 1'b0;
    logic            conv_done = 1'b0;
    logic            load_BRAM_dina, update_BRAM_doutb, conv_start, acc_clear, och_done;
    logic            busy, done, err;
    logic [CH_W-1:0] in_ch_idx, out_ch_idx;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_cstart, n_aclr, n_load, n_ochd, n_done;
    int lat_ll, lat_upd, lat_cs;
    bit load_prev = 1'b0;
    bit cd_en = 1'b1;
    bit ll_en = 1'b1;
    bit lc_follow = 1'b1;
    int lc_size = 3;
    bit ok;

    kernel_sched #(.CH_W(CH_W), .WDOG_CYCLES(100)) dut (
        .clk               (clk),
        .Reset             (Reset),
        .start             (start),
        .abort             (abort),
        .CHANNEL_SIZE      (CHANNEL_SIZE),
        .OUT_CHANNEL_SIZE  (OUT_CHANNEL_SIZE),
        .last_loading_1ker (last_loading_1ker),
        .last_channel      (last_channel),
        .conv_done         (conv_done),
        .load_BRAM_dina    (load_BRAM_dina),
        .update_BRAM_doutb (update_BRAM_doutb),
        .conv_start        (conv_start),
        .acc_clear         (acc_clear),
        .och_done          (och_done),
        .in_ch_idx         (in_ch_idx),
        .out_ch_idx        (out_ch_idx),
        .busy              (busy),
        .done              (done),
        .err               (err)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=%0d expected=finish", cyc);
        $fatal(1, "bench timeout");
    end

    // Pulse counters and latency probe, all sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (conv_start) n_cstart++;
        if (acc_clear) n_aclr++;
        if (och_done) n_ochd++;
        if (done) n_done++;
        if (load_BRAM_dina && !load_prev) n_load++;
        load_prev = load_BRAM_dina;
        if (last_loading_1ker && lat_ll < 0) lat_ll = cyc;
        if (update_BRAM_doutb && lat_ll >= 0 && lat_upd < 0) lat_upd = cyc;
        if (conv_start && lat_upd >= 0 && lat_cs < 0) lat_cs = cyc;
    end

    // Conv engine model: conv_done five cycles after each conv_start.
    initial forever begin
        @(negedge clk);
        if (cd_en && conv_start) begin
            repeat (5) @(posedge clk);
            #1 conv_done = 1'b1;
            @(posedge clk);
            #1 conv_done = 1'b0;
        end
    end

    // Kernel BRAM model: final kernel word one cycle after load mode is seen.
    initial forever begin
        @(negedge clk);
        if (ll_en && load_BRAM_dina) begin
            @(posedge clk);
            #1 last_loading_1ker = 1'b1;
            @(posedge clk);
            #1 last_loading_1ker = 1'b0;
            repeat (2) @(posedge clk);
        end
    end

    // Read address model: last_channel tracks the final input channel.
    initial forever begin
        @(negedge clk);
        last_channel = lc_follow && (int'(in_ch_idx) == lc_size - 1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_cstart = 0; n_aclr = 0; n_load = 0; n_ochd = 0; n_done = 0;
        lat_ll = -1; lat_upd = -1; lat_cs = -1;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        tick();
    endtask

    task automatic pulse_start(input int ch, input int och);
        CHANNEL_SIZE     = CH_W'(ch);
        OUT_CHANNEL_SIZE = CH_W'(och);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int c0, c1;
        clear_counts();

        // Reset state
        #2 Reset = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_outs", 32'({load_BRAM_dina, update_BRAM_doutb, conv_start, acc_clear, och_done, done, err}), 32'd0);
        check("rst_idx", 32'({in_ch_idx, out_ch_idx}), 32'd0);
        tick(); tick();
        Reset = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Nominal layer 3x2; size inputs and a second start while busy are ignored
        clear_counts();
        lc_size = 3;
        pulse_start(3, 2);
        CHANNEL_SIZE = CH_W'(7);
        OUT_CHANNEL_SIZE = CH_W'(5);
        check("nom_busy", 32'(busy), 32'd1);
        repeat (20) tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_done(400, ok);
        tick();
        check("nom_done_seen", 32'(ok), 32'd1);
        check("nom_conv_start", 32'(n_cstart), 32'd6);
        check("nom_acc_clear", 32'(n_aclr), 32'd2);
        check("nom_load_phases", 32'(n_load), 32'd2);
        check("nom_och_done", 32'(n_ochd), 32'd2);
        check("nom_done_count", 32'(n_done), 32'd1);
        check("nom_err", 32'(err), 32'd0);
        check("nom_idx", 32'({in_ch_idx, out_ch_idx}), 32'd0);
        check("nom_busy_end", 32'(busy), 32'd0);
        check("lat_update", 32'(lat_upd - lat_ll), 32'd2);
        check("lat_conv_start", 32'(lat_cs - lat_ll), 32'd3);

        // Zero channel size
        clear_counts();
        pulse_start(0, 2);
        check("zs_done_early", 32'(done), 32'd0);
        check("zs_err", 32'(err), 32'd1);
        tick();
        check("zs_done", 32'(done), 32'd1);
        tick();
        check("zs_done_once", 32'(done), 32'd0);
        check("zs_busy", 32'(busy), 32'd0);
        check("zs_no_load", 32'(n_load), 32'd0);

        // Abort in WAIT at out_ch_idx=1, in_ch_idx=2
        clear_counts();
        pulse_start(3, 2);
        check("ab_err_cleared", 32'(err), 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (conv_start && in_ch_idx == CH_W'(2) && out_ch_idx == CH_W'(1)) ok = 1'b1;
        end
        check("ab_reached", 32'(ok), 32'd1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_pulses", 32'({load_BRAM_dina, update_BRAM_doutb, conv_start, acc_clear, och_done, done}), 32'd0);
        check("ab_idx", 32'({in_ch_idx, out_ch_idx}), 32'd0);
        repeat (12) tick();
        check("ab_no_done", 32'(n_done), 32'd0);
        clear_counts();
        pulse_start(3, 2);
        wait_done(400, ok);
        check("ab_rerun_done", 32'(ok), 32'd1);
        check("ab_rerun_conv", 32'(n_cstart), 32'd6);
        check("ab_rerun_och", 32'(n_ochd), 32'd2);
        check("ab_rerun_err", 32'(err), 32'd0);

        // last_channel stuck low with CHANNEL_SIZE=2
        clear_counts();
        lc_follow = 1'b0;
        pulse_start(2, 1);
        wait_done(300, ok);
        lc_follow = 1'b1;
        check("cf_done", 32'(ok), 32'd1);
        check("cf_err", 32'(err), 32'd1);
        check("cf_conv", 32'(n_cstart), 32'd2);

        // Reset asserted while in LOAD
        clear_counts();
        ll_en = 1'b0;
        pulse_start(2, 1);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (load_BRAM_dina) ok = 1'b1;
        end
        check("rm_in_load", 32'(ok), 32'd1);
        Reset = 1'b0;
        #1;
        check("rm_outs", 32'({load_BRAM_dina, update_BRAM_doutb, conv_start, acc_clear, och_done, done, err, busy}), 32'd0);
        tick(); tick();
        Reset = 1'b1;
        ll_en = 1'b1;
        tick();
        check("rm_idle", 32'(busy), 32'd0);
        lc_size = 2;
        pulse_start(2, 1);
        wait_done(300, ok);
        check("rm_resume_done", 32'(ok), 32'd1);
        check("rm_resume_err", 32'(err), 32'd0);

`ifdef KSCHED_WDOG_EN
        // Watchdog: conv_done withheld, IDLE 100 cycles after WAIT entry
        clear_counts();
        cd_en = 1'b0;
        pulse_start(2, 1);
        ok = 1'b0;
        c0 = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (conv_start) begin ok = 1'b1; c0 = cyc; end
        end
        check("wd_wait_entry", 32'(ok), 32'd1);
        ok = 1'b0;
        c1 = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; c1 = cyc; end
        end
        check("wd_idle", 32'(ok), 32'd1);
        check("wd_delay", 32'(c1 - c0), 32'd100);
        check("wd_err", 32'(err), 32'd1);
        check("wd_no_done", 32'(n_done), 32'd0);
        cd_en = 1'b1;
        tick();
`else
        c0 = 0;
        c1 = c0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
